bash_f_seq: RTL and testbench
=============================

Name: bash_f_seq

Overview:
- Iterative sequencer for the bash-f sponge permutation (STB 34.101.77). It applies the full 24-round transform to a 1536-bit state, one round per clock.
- Each round uses 8 bash_s column instances, then the word permutation P, then the round-constant XOR.
- It sits between the bash hash/AE mode controller (sponge absorb/squeeze) and the bash_s datapath.
- Valid/ready handshake on both the input and output sides.

Parameters:
- ROUNDS, 24, number of rounds executed (1..24); values below 24 are for debug/test only, using the first ROUNDS constants.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- in_valid_i  input  1  input state valid
- in_ready_o  output  1  block can accept a state
- in_state_i  input  1536  S[i] = in_state_i[64*i +: 64], i = 0..23
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- out_state_o  output  1536  result, same packing
- busy_o  output  1  rounds in progress
- round_o  output  5  current round index 0..23 (debug)

Behaviour:
- Word convention: bus words are byte strings with byte 0 in bits [63:56]. bash_s performs its own byte swaps. Round constants are byte-swapped (bswap64) before XOR.
- FSM states: IDLE, RUN, DONE.
- Reset (sync, rst_i=1 at an edge): state=IDLE, internal state register=0, round counter=0, constant register=C1. Outputs: in_ready_o=1, out_valid_o=0, busy_o=0, round_o=0, out_state_o=0.
- IDLE: in_ready_o=1. On in_valid_i&&in_ready_o: load S←in_state_i, rnd←0, C←C1=0x3BF5080AC8BA94B1, go to RUN.
- RUN: in_ready_o=0, busy_o=1. Each edge applies one round:
  - For column i=0..7, (S[i],S[8+i],S[16+i]) ← bash_s with (M1,N1,M2,N2) taken from the fixed per-column sequence. Start at (8,53,14,1); each next column multiplies every value by 7 mod 64. Column 1 is (56,51,34,7).
  - Then S'[k] ← S[P[k]], P = 15,10,9,12,11,14,13,8,17,16,19,18,21,20,23,22,6,3,0,5,2,7,4,1.
  - Then S'[23] ^= bswap64(C).
  - Then C ← (C>>1) ^ (C[0] ? 0xDC2BE1997FE0D8AE : 0), and rnd ← rnd+1.
  - The round with rnd==ROUNDS-1 transitions to DONE.
- DONE: out_valid_o=1; out_state_o=S held stable until the handshake. On out_ready_i go to IDLE, clearing out_valid_o; S is retained.
- Latency: input accepted at edge 0 → out_valid_o high after edge ROUNDS (24). Throughput is one permutation per ROUNDS+1 cycles minimum, plus 1 idle cycle before the next accept.
- in_valid_i is ignored outside IDLE; no queuing.
- out_ready_i held high in DONE gives a single-cycle out_valid_o pulse.
- Reset mid-RUN or in DONE: abort immediately to the reset values; no partial result is emitted.
- round_o = rnd in RUN; 0 otherwise.

Decomposition:
- Package bash_pkg:
  - bash_state_t (24×64 array)
  - BASH_C1 and BASH_CPOLY constants
  - BASH_P index table
  - per-column rotation table (m1,n1,m2,n2)[0..7]
  - bswap64 function
- Sub-module bash_f_round (combinational): 8 bash_s instances, P, constant XOR; inputs state and C, output next state.
- bash_f_seq contains the FSM, state register, round counter and constant LFSR.

Test Plan:
- Constant LFSR: after accept, C at rnd=1 is 0xC1D1659C1BBD92F6 (probe via hierarchy) → matches.
- ROUNDS=1, all-zero input → S[0..15]=0, S[16..22]=0xFFFFFFFFFFFFFFFF, S[23]=0x4E6B4537F5F70AC4; out_valid_o asserted exactly 1 cycle after accept edge.
- ROUNDS=24, STB 34.101.77 Table A bash-f input (S[0]=0xB194BAC80A08F53B…) → output equals the standard's bash-f output vector; out_valid_o rises 24 cycles after accept; round_o counts 0..23.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE → out_state_o stable, in_ready_o=0 throughout, in_valid_i pulses ignored; release → one transfer, IDLE next cycle.
- Reset at rnd=12 → next cycle in_ready_o=1, out_valid_o=0, busy_o=0; a new vector then produces the correct KAT result.
- Back-to-back: two random states with in_valid_i and out_ready_i held high → two results matching the C reference model, each 24 cycles after its accept.

Source files
------------

// File: rtl/bash_pkg.sv
// Shared types, constants and helpers for the bash-f permutation datapath.
package bash_pkg;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned NWORDS  = 24;
    localparam int unsigned NCOLS   = 8;
    localparam int unsigned STATE_W = WORD_W * NWORDS;
    localparam int unsigned RND_W   = 5;

    typedef logic [WORD_W-1:0] bash_word_t;
    // Word i occupies bits [64*i +: 64], matching the bus packing.
    typedef bash_word_t [NWORDS-1:0] bash_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bash_fsm_t;

    localparam bash_word_t BASH_C1    = 64'h3BF5080AC8BA94B1;
    localparam bash_word_t BASH_CPOLY = 64'hDC2BE1997FE0D8AE;

    localparam int unsigned BASH_P [NWORDS] = '{
        15, 10,  9, 12, 11, 14, 13,  8,
        17, 16, 19, 18, 21, 20, 23, 22,
         6,  3,  0,  5,  2,  7,  4,  1
    };

    typedef struct packed {
        int unsigned m1;
        int unsigned n1;
        int unsigned m2;
        int unsigned n2;
    } bash_rot_t;

    // Column c uses the column-0 amounts scaled by 7^c mod 64.
    localparam bash_rot_t BASH_ROT [NCOLS] = '{
        '{ 8, 53, 14,  1},
        '{56, 51, 34,  7},
        '{ 8, 37, 46, 49},
        '{56,  3,  2, 23},
        '{ 8, 21, 14, 33},
        '{56, 19, 34, 39},
        '{ 8,  5, 46, 17},
        '{56, 35,  2, 55}
    };

    function automatic bash_word_t bswap64(input bash_word_t x);
        bash_word_t r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = x[8*(7-b) +: 8];
        end
        return r;
    endfunction

    function automatic bash_word_t rot_hi(input bash_word_t x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

endpackage

// File: rtl/bash_f_round.sv
// One bash-f round: 8 bash-s columns, word permutation, round-constant XOR.
module bash_f_round
    import bash_pkg::*;
(
    input  bash_state_t state,
    input  bash_word_t  c,
    output bash_state_t next_state_c
);

    bash_state_t mixed;

    for (genvar i = 0; i < NCOLS; i++) begin : g_col
        bash_s #(
            .M1(BASH_ROT[i].m1),
            .N1(BASH_ROT[i].n1),
            .M2(BASH_ROT[i].m2),
            .N2(BASH_ROT[i].n2)
        ) u_s (
            .w0  (state[i]),
            .w1  (state[NCOLS+i]),
            .w2  (state[2*NCOLS+i]),
            .y0_c(mixed[i]),
            .y1_c(mixed[NCOLS+i]),
            .y2_c(mixed[2*NCOLS+i])
        );
    end

    // Constant is kept as a number; the bus word is a byte string.
    for (genvar k = 0; k < NWORDS; k++) begin : g_perm
        if (k == NWORDS - 1) begin : g_last
            assign next_state_c[k] = mixed[BASH_P[k]] ^ bswap64(c);
        end else begin : g_pass
            assign next_state_c[k] = mixed[BASH_P[k]];
        end
    end

endmodule

// File: rtl/bash_s.sv
// bash-s S-box column: three bus words in, three bus words out (byte swaps internal).
module bash_s
    import bash_pkg::*;
#(
    parameter int unsigned M1 = 8,
    parameter int unsigned N1 = 53,
    parameter int unsigned M2 = 14,
    parameter int unsigned N2 = 1
) (
    input  bash_word_t w0,
    input  bash_word_t w1,
    input  bash_word_t w2,
    output bash_word_t y0_c,
    output bash_word_t y1_c,
    output bash_word_t y2_c
);

    bash_word_t x0, x1, x2;
    bash_word_t t1, t2;
    bash_word_t u0, u1, u2;

    always_comb begin
        x0 = bswap64(w0);
        x1 = bswap64(w1);
        x2 = bswap64(w2);
        t2 = rot_hi(x0, M1);
        u0 = x0 ^ x1 ^ x2;
        t1 = x1 ^ rot_hi(u0, N1);
        u1 = t1 ^ t2;
        u2 = x2 ^ rot_hi(x2, M2) ^ rot_hi(t1, N2);
        // Nonlinear layer uses the pre-update u0/u1/u2 for all three outputs.
        y0_c = bswap64(u0 ^ (~u2 | u1));
        y1_c = bswap64(u1 ^ (u0 | u2));
        y2_c = bswap64(u2 ^ (u0 & u1));
    end

endmodule

// File: rtl/bash_f_seq.sv
// Iterative bash-f sequencer: one round per clock, valid/ready on both sides.
module bash_f_seq
    import bash_pkg::*;
#(
    parameter int unsigned ROUNDS = 24
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [STATE_W-1:0] in_state_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [STATE_W-1:0] out_state_o,
    output logic               busy_o,
    output logic [RND_W-1:0]   round_o
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

    bash_fsm_t   state_q;
    bash_state_t s_q;
    bash_state_t round_next_c;
    bash_word_t  c_q;
    logic [RND_W-1:0] rnd_q;

    bash_f_round u_round (
        .state       (s_q),
        .c           (c_q),
        .next_state_c(round_next_c)
    );

    assign out_state_o = s_q;
    // rnd_q is returned to zero on leaving RUN, so it doubles as round_o.
    assign round_o     = rnd_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            s_q         <= '0;
            rnd_q       <= '0;
            c_q         <= BASH_C1;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        s_q        <= in_state_i;
                        rnd_q      <= '0;
                        c_q        <= BASH_C1;
                        state_q    <= RUN;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end
                RUN: begin
                    s_q <= round_next_c;
                    c_q <= (c_q >> 1) ^ (c_q[0] ? BASH_CPOLY : '0);
                    if (rnd_q == LAST_RND) begin
                        rnd_q       <= '0;
                        state_q     <= DONE;
                        busy_o      <= 1'b0;
                        out_valid_o <= 1'b1;
                    end else begin
                        rnd_q <= RND_W'(rnd_q + RND_W'(1));
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    rnd_q       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bash_f_seq.sv
// Randomized scoreboard bench for bash_f_seq against a word-level bash-f model.
module tb_bash_f_seq;

    localparam int NR = 24;
    localparam logic [63:0] C1   = 64'h3BF5080AC8BA94B1;
    localparam logic [63:0] POLY = 64'hDC2BE1997FE0D8AE;
    localparam int PERM [24] = '{15, 10, 9, 12, 11, 14, 13, 8, 17, 16, 19, 18,
                                 21, 20, 23, 22, 6, 3, 0, 5, 2, 7, 4, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
    logic [1535:0]  in_state = '0, out_state;
    logic [4:0]     round_idx;
    logic           in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, busy1;
    logic [1535:0]  in_state1 = '0, out_state1;
    logic [4:0]     round_idx1;

    bash_f_seq #(.ROUNDS(NR)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_state_i(in_state), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_state_o(out_state), .busy_o(busy), .round_o(round_idx));

    bash_f_seq #(.ROUNDS(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .in_state_i(in_state1), .out_valid_o(out_valid1), .out_ready_i(out_ready1),
        .out_state_o(out_state1), .busy_o(busy1), .round_o(round_idx1));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1535:0] st;
        int            acc;
    } exp_t;
    exp_t sb[$];
    int   acc_log[$];

    // ---- reference model: standard word domain (little-endian numbers) ----
    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [1535:0] ref_f(input logic [1535:0] st, input int rounds);
        logic [63:0] w [24];
        logic [63:0] v [24];
        logic [63:0] c, a, b, d, t1, t2, tmp;
        int m1, n1, m2, n2;
        logic [1535:0] res;
        c = C1;
        for (int i = 0; i < 24; i++) begin
            tmp = st[64*i +: 64];
            w[i] = {<<8{tmp}};
        end
        for (int r = 0; r < rounds; r++) begin
            m1 = 8; n1 = 53; m2 = 14; n2 = 1;
            for (int i = 0; i < 8; i++) begin
                a = w[i]; b = w[8+i]; d = w[16+i];
                t2 = rotl(a, m1);
                a  = a ^ b ^ d;
                t1 = b ^ rotl(a, n1);
                b  = t1 ^ t2;
                d  = d ^ rotl(d, m2) ^ rotl(t1, n2);
                w[i]    = a ^ (~d | b);
                w[8+i]  = b ^ (a | d);
                w[16+i] = d ^ (a & b);
                m1 = (m1 * 7) % 64; n1 = (n1 * 7) % 64;
                m2 = (m2 * 7) % 64; n2 = (n2 * 7) % 64;
            end
            for (int k = 0; k < 24; k++) v[k] = w[PERM[k]];
            v[23] = v[23] ^ c;
            c = (c >> 1) ^ (c[0] ? POLY : 64'd0);
            w = v;
        end
        for (int i = 0; i < 24; i++) begin
            tmp = w[i];
            res[64*i +: 64] = {<<8{tmp}};
        end
        return res;
    endfunction

    function automatic logic [1535:0] rand_state();
        logic [1535:0] s;
        for (int i = 0; i < 24; i++) s[64*i +: 64] = {$urandom, $urandom};
        return s;
    endfunction

    // ---- comparison helpers ----
    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [1535:0] act, input logic [1535:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int i = 23; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: word %0d got %h expected %h", name, bad,
                     act[64*bad +: 64], exp[64*bad +: 64]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---- input monitor: predicts result at each accept ----
    always @(negedge clk) begin : in_mon
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            e.st  = ref_f(in_state, NR);
            e.acc = cyc + 1;
            sb.push_back(e);
            acc_log.push_back(cyc + 1);
        end
    end

    // ---- output monitor: latency, hold stability, result ----
    logic          prev_v = 1'b0;
    logic [1535:0] prev_s = '0;
    always @(negedge clk) begin : out_mon
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got valid with no pending input at cycle %0d", cyc);
                end else begin
                    if (!prev_v)
                        check_val("latency", 64'(cyc - sb[0].acc), 64'(NR));
                    else
                        check_state("hold_stable", out_state, prev_s);
                    if (out_ready) begin
                        check_state("result", out_state, sb[0].st);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_v = out_valid;
            prev_s = out_state;
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding expected 0 after %0d cycles", sb.size(), budget);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

    logic [1535:0] kat_vec, held, exp1;
    int            n_acc;
    logic          take;

    initial begin
        for (int i = 0; i < 24; i++)
            kat_vec[64*i +: 64] = 64'hB194BAC80A08F53B ^ (64'(i) * 64'h9E3779B97F4A7C15);

        repeat (2) step();
        rst = 1'b0;
        step();

        // reset values
        check_val("rst_in_ready",  64'(in_ready),  64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_busy",      64'(busy),      64'd0);
        check_val("rst_round",     64'(round_idx), 64'd0);
        check_state("rst_out_state", out_state, '0);

        // single-round instance, all-zero input
        in_state1 = '0;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        check_val("r1_valid_at_accept", 64'(out_valid1), 64'd0);
        check_val("r1_busy", 64'(busy1), 64'd1);
        step();
        check_val("r1_valid_next", 64'(out_valid1), 64'd1);
        for (int i = 0; i < 16; i++) exp1[64*i +: 64] = 64'd0;
        for (int i = 16; i < 23; i++) exp1[64*i +: 64] = '1;
        exp1[64*23 +: 64] = 64'h4E6B4537F5F70AC4;
        check_state("r1_zero_kat", out_state1, exp1);
        check_state("r1_model", out_state1, ref_f('0, 1));
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check_val("r1_valid_cleared", 64'(out_valid1), 64'd0);
        check_val("r1_ready_back", 64'(in_ready1), 64'd1);

        // full run: constant LFSR, round counter, backpressure
        in_state = kat_vec;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check_val("c_at_rnd0", dut.c_q, C1);
        check_val("round_0", 64'(round_idx), 64'd0);
        check_val("busy_run", 64'(busy), 64'd1);
        check_val("in_ready_run", 64'(in_ready), 64'd0);
        step();
        check_val("c_at_rnd1", dut.c_q, 64'hC1D1659C1BBD92F6);
        check_val("round_1", 64'(round_idx), 64'd1);
        for (int k = 2; k < NR; k++) begin
            step();
            check_val($sformatf("round_%0d", k), 64'(round_idx), 64'(k));
        end
        step();
        check_val("done_valid", 64'(out_valid), 64'd1);
        check_val("done_busy", 64'(busy), 64'd0);
        check_val("done_round", 64'(round_idx), 64'd0);
        held = out_state;
        for (int j = 0; j < 10; j++) begin
            in_valid = j[0];
            in_state = rand_state();
            step();
            check_val("bp_in_ready", 64'(in_ready), 64'd0);
            check_val("bp_out_valid", 64'(out_valid), 64'd1);
            check_state("bp_hold", out_state, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("after_xfer_valid", 64'(out_valid), 64'd0);
        check_val("after_xfer_ready", 64'(in_ready), 64'd1);
        check_val("sb_after_xfer", 64'(sb.size()), 64'd0);

        // reset mid-run
        in_state = rand_state();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (12) step();
        check_val("round_12", 64'(round_idx), 64'd12);
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        check_val("abort_in_ready", 64'(in_ready), 64'd1);
        check_val("abort_out_valid", 64'(out_valid), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_round", 64'(round_idx), 64'd0);
        check_state("abort_state", out_state, '0);
        in_state = kat_vec;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        drain(40);

        // back-to-back random states, both handshakes held high
        for (int t = 0; t < 3; t++) begin
            n_acc = 0;
            in_state = rand_state();
            in_valid = 1'b1;
            out_ready = 1'b1;
            for (int n = 0; n < 120 && n_acc < 2; n++) begin
                take = in_valid && in_ready;
                step();
                if (take) begin
                    n_acc++;
                    in_state = rand_state();
                end
            end
            in_valid = 1'b0;
            check_val("b2b_accepts", 64'(n_acc), 64'd2);
            drain(40);
            if (acc_log.size() >= 2)
                check_val("b2b_spacing",
                          64'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]),
                          64'(NR + 2));
        end
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
